// File: rtl/logic_seq_unit_pkg.sv
// Shared definitions for the slice-serial bitwise logic unit: operation
// encodings, FSM state encoding and default datapath geometry.
package logic_seq_unit_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_SLICE = 4;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_NOR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Slice counter width; a single-slice configuration still needs one bit.
    function automatic int cnt_width(input int n_slices);
        return (n_slices > 1) ? $clog2(n_slices) : 1;
    endfunction

endpackage

// File: rtl/logic_seq_unit_slice.sv
// Combinational per-slice bitwise operator, time-multiplexed by the top.
module logic_slice
    import logic_seq_unit_pkg::*;
#(
    parameter int SLICE = DEF_SLICE
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  op_e              op,
    output logic [SLICE-1:0] y
);

    // Pure bitwise operation; no carries cross bit positions.
    always_comb begin
        y = '0;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NOR:  y = ~(a | b);
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/logic_seq_unit.sv
// Slice-serial bitwise logic unit. Operands are captured on an accepted start,
// then processed SLICE bits per cycle, LSB slice first, through one shared
// logic_slice. The result register Y only moves on entry to DONE.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | waiting for start; outputs hold the last completed result
//   ST_RUN  | one slice per cycle; busy=1; start ignored
//   ST_DONE | single-cycle done pulse; start here chains the next op
module logic_seq_unit
    import logic_seq_unit_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SLICE = DEF_SLICE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Y,
    output logic             busy,
    output logic             done,
    output logic             zero
);

    localparam int            NSL = WIDTH / SLICE;
    localparam int            CW  = cnt_width(NSL);
    localparam logic [CW-1:0] TC  = CW'(NSL - 1);

    state_e           state_q;
    state_e           state_d;
    logic             accept;
    logic             last_slice;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    op_e              op_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_nx;
    logic [SLICE-1:0] slice_y;
    logic [WIDTH-1:0] y_q;
    logic             zero_q;

    logic_slice #(.SLICE(SLICE)) u_slice (
        .a  (a_q[SLICE-1:0]),
        .b  (b_q[SLICE-1:0]),
        .op (op_q),
        .y  (slice_y)
    );

    // The accumulator fills from the top so that after NSL shifts the first
    // (LSB) slice has landed at bit 0.
    generate
        if (NSL > 1) begin : g_multi
            assign acc_nx = {slice_y, acc_q[WIDTH-1:SLICE]};
        end else begin : g_single
            assign acc_nx = slice_y;
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic, accept strobe and status outputs.
    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        last_slice = (cnt_q == TC);
        busy       = (state_q == ST_RUN);
        done       = (state_q == ST_DONE);
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (last_slice) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand capture, slice shifting, counter and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= OP_AND;
            cnt_q  <= '0;
            acc_q  <= '0;
            y_q    <= '0;
            zero_q <= 1'b1;
        end else if (accept) begin
            a_q   <= A;
            b_q   <= B;
            op_q  <= op_e'(op);
            cnt_q <= '0;
            acc_q <= '0;
        end else if (state_q == ST_RUN) begin
            a_q   <= a_q >> SLICE;
            b_q   <= b_q >> SLICE;
            acc_q <= acc_nx;
            if (last_slice) begin
                // Result lands together with the DONE state.
                y_q    <= acc_nx;
                zero_q <= (acc_nx == '0);
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign Y    = y_q;
    assign zero = zero_q;

endmodule

// File: tb/tb_logic_seq_unit.sv
// Directed bench for logic_seq_unit at default geometry (32 bits, 4-bit slices).
module tb_logic_seq_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] Y;
    logic        busy;
    logic        done;
    logic        zero;

    int errors = 0;
    int checks = 0;

    logic_seq_unit #(.WIDTH(32), .SLICE(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .Y     (Y),
        .busy  (busy),
        .done  (done),
        .zero  (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Counts rising edges until done is seen (sampled 1 time unit after each
    // edge), with a bound; also counts busy cycles and notes any Y movement.
    task automatic wait_done(output int edges, output int busy_cnt, output bit y_moved);
        logic [31:0] y0;
        bit got;
        y0 = Y;
        edges = 0;
        busy_cnt = 0;
        y_moved = 1'b0;
        got = 1'b0;
        while (!got && edges < 30) begin
            @(posedge clk);
            #1;
            edges++;
            if (done) got = 1'b1;
            else begin
                if (busy) busy_cnt++;
                if (Y !== y0) y_moved = 1'b1;
            end
        end
    endtask

    // One isolated operation from IDLE: start pulse, then check latency,
    // busy duration, result stability during RUN, result and single done.
    task automatic run_op(input string tag, input logic [1:0] o,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ey, input logic ez);
        int n, bc;
        bit moved;
        @(negedge clk);
        start = 1'b1; op = o; A = a; B = b;
        @(posedge clk);
        #1;
        chk({tag, "_busy_first"}, {31'd0, busy}, 32'd1);
        @(negedge clk);
        start = 1'b0;
        A = ~a; B = ~b; op = ~o;
        wait_done(n, bc, moved);
        // done on the 9th edge counting the sampling edge: 8 edges after it
        chk({tag, "_latency"}, n, 32'd8);
        chk({tag, "_busy_cycles"}, bc + 1, 32'd8);
        chk({tag, "_y_stable"}, {31'd0, moved}, 32'd0);
        chk({tag, "_y"}, Y, ey);
        chk({tag, "_zero"}, {31'd0, zero}, {31'd0, ez});
        chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        chk({tag, "_done_single"}, {31'd0, done}, 32'd0);
    endtask

    initial begin : stim
        int n, bc, dcount;
        bit moved;

        rst = 1'b0; start = 1'b0; op = 2'b00; A = '0; B = '0;
        #1 rst = 1'b1;
        #2;
        chk("reset_y", Y, 32'h0);
        chk("reset_zero", {31'd0, zero}, 32'd1);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_op("and_basic", 2'b00, 32'h17F13EE8, 32'hB0997F07, 32'h10913E00, 1'b0);
        run_op("and_ones",  2'b00, 32'hFFFFFFFF, 32'hB0997F07, 32'hB0997F07, 1'b0);
        run_op("and_zero",  2'b00, 32'h00000000, 32'hB0997F07, 32'h00000000, 1'b1);
        run_op("nor_zero",  2'b11, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0);
        run_op("xor_equal", 2'b10, 32'h51310052, 32'h51310052, 32'h00000000, 1'b1);

        // start during RUN cycle 3 with new operands must be ignored
        @(negedge clk);
        start = 1'b1; op = 2'b01; A = 32'h12345678; B = 32'h0F0F0000;
        @(posedge clk); #1;
        @(negedge clk); start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        start = 1'b1; A = 32'hFFFFFFFF; B = 32'hFFFFFFFF; op = 2'b00;
        @(posedge clk); #1;
        chk("or_ignore_busy", {31'd0, busy}, 32'd1);
        @(negedge clk); start = 1'b0;
        wait_done(n, bc, moved);
        chk("or_ignore_latency", n, 32'd5);
        chk("or_ignore_y", Y, 32'h1F3F5678);
        chk("or_ignore_zero", {31'd0, zero}, 32'd0);
        dcount = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (done) dcount++;
        end
        chk("or_ignore_no_second_done", dcount, 32'd0);

        // start held high: back-to-back operations, one every 9 cycles
        @(negedge clk);
        start = 1'b1; op = 2'b10; A = 32'hF0F0F0F0; B = 32'h0FF00FF0;
        @(posedge clk); #1;
        op = 2'b00; A = 32'h12345678; B = 32'hFFFFFFFF;
        wait_done(n, bc, moved);
        chk("b2b_first_latency", n, 32'd8);
        chk("b2b_first_y", Y, 32'hFF00FF00);
        @(posedge clk); #1;
        chk("b2b_rechain_busy", {31'd0, busy}, 32'd1);
        op = 2'b01; A = 32'hAAAAAAAA; B = 32'h55555555;
        wait_done(n, bc, moved);
        chk("b2b_second_period", n + 1, 32'd9);
        chk("b2b_second_y", Y, 32'h12345678);
        @(posedge clk); #1;
        op = 2'b11; A = 32'h0; B = 32'h0;
        wait_done(n, bc, moved);
        chk("b2b_third_period", n + 1, 32'd9);
        chk("b2b_third_y", Y, 32'hFFFFFFFF);
        chk("b2b_third_zero", {31'd0, zero}, 32'd0);
        @(negedge clk); start = 1'b0;
        @(posedge clk); #1;
        chk("b2b_back_idle_busy", {31'd0, busy}, 32'd0);
        chk("b2b_back_idle_done", {31'd0, done}, 32'd0);

        // reset in RUN cycle 5 aborts the operation asynchronously
        @(negedge clk);
        start = 1'b1; op = 2'b00; A = 32'hFFFFFFFF; B = 32'hFFFFFFFF;
        @(posedge clk); #1;
        @(negedge clk); start = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("abort_y", Y, 32'h0);
        chk("abort_zero", {31'd0, zero}, 32'd1);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        @(negedge clk); rst = 1'b0;
        dcount = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done || busy) dcount++;
        end
        chk("abort_no_done", dcount, 32'd0);

        run_op("and_after_reset", 2'b00, 32'hDEADBEEF, 32'h0000FFFF, 32'h0000BEEF, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
